// File: rtl/nbcac_13di_pkg.sv
// ----------------------------------------------------------------------------
// nbcac_13di_pkg
// Shared constants for the 13-bit NBCAC crosstalk-avoidance codec.
// The encoder and the decoder core use the same weight table, so it lives
// here.
//   DATA_W  : data word width (13)
//   CODE_W  : codeword width on the bus (18)
//   WEIGHTS : s1..s18, indexed by the codeword position k of d[k]
//   state_t : encoder FSM states
// ----------------------------------------------------------------------------
package nbcac_13di_pkg;

    localparam int DATA_W = 13;
    localparam int CODE_W = 18;

    // s2..s18 follow a Fibonacci-like recurrence, so greedy subtraction in
    // descending order always reaches zero for any even value up to 8190.
    localparam logic [15:0] WEIGHTS [1:18] = '{
        16'd1,    16'd3194, 16'd1974, 16'd1220, 16'd754,  16'd466,
        16'd288,  16'd178,  16'd110,  16'd68,   16'd42,   16'd26,
        16'd16,   16'd10,   16'd6,    16'd4,    16'd2,    16'd2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbcac_13di_encoder_seq_weight_rom.sv
// ----------------------------------------------------------------------------
// nbcac_13di_weight_rom
// Combinational lookup of the weight s_idx used by one greedy step.
// Only positions 2..18 take part in the iteration; every other index
// returns 0.
//   idx    : codeword position k (5 bits)
//   weight : s_k truncated to 13 bits (all weights fit)
// ----------------------------------------------------------------------------
module nbcac_13di_weight_rom
    import nbcac_13di_pkg::*;
(
    input  logic [4:0]  idx,
    output logic [12:0] weight
);

    // Index-to-weight table for the iterative positions
    always_comb begin
        weight = 13'd0;
        case (idx)
            5'd2:    weight = WEIGHTS[2][12:0];
            5'd3:    weight = WEIGHTS[3][12:0];
            5'd4:    weight = WEIGHTS[4][12:0];
            5'd5:    weight = WEIGHTS[5][12:0];
            5'd6:    weight = WEIGHTS[6][12:0];
            5'd7:    weight = WEIGHTS[7][12:0];
            5'd8:    weight = WEIGHTS[8][12:0];
            5'd9:    weight = WEIGHTS[9][12:0];
            5'd10:   weight = WEIGHTS[10][12:0];
            5'd11:   weight = WEIGHTS[11][12:0];
            5'd12:   weight = WEIGHTS[12][12:0];
            5'd13:   weight = WEIGHTS[13][12:0];
            5'd14:   weight = WEIGHTS[14][12:0];
            5'd15:   weight = WEIGHTS[15][12:0];
            5'd16:   weight = WEIGHTS[16][12:0];
            5'd17:   weight = WEIGHTS[17][12:0];
            5'd18:   weight = WEIGHTS[18][12:0];
            default: weight = 13'd0;
        endcase
    end

endmodule

// File: rtl/nbcac_13di_encoder_seq.sv
// ----------------------------------------------------------------------------
// nbcac_13di_encoder_seq
// Iterative NBCAC encoder: maps a 13-bit word v onto an 18-bit codeword
// d[18:1] whose weighted sum (weights s1..s18) equals v. d[1] is v[0]
// directly; the even remainder is consumed greedily, one weight per clock,
// in descending order (s2 first, s18 last).
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : v_in carries a word to encode
//   in_ready   : encoder is IDLE and will accept a word
//   v_in       : data word
//   out_valid  : d_out carries a finished codeword (DONE)
//   out_ready  : consumer takes d_out
//   d_out      : codeword; d_out[k-1] carries d[k]
//   busy       : high while iterating (RUN)
// Accept edge to out_valid is 17 clocks; minimum spacing is 19 clocks.
// ----------------------------------------------------------------------------
module nbcac_13di_encoder_seq
    import nbcac_13di_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] v_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] d_out,
    output logic        busy
);

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  idx_r;
    logic [12:0] rem_r;
    logic [17:0] code_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;

    logic [12:0] weight_s;
    logic        take_s;
    logic [17:0] set_mask_s;

    nbcac_13di_weight_rom u_rom (
        .idx    (idx_r),
        .weight (weight_s)
    );

    // Greedy step decision: the compare guards the subtraction against underflow
    always_comb begin
        take_s     = 1'b0;
        set_mask_s = 18'd0;
        if (rem_r >= weight_s) begin
            take_s     = 1'b1;
            set_mask_s = 18'd1 << (idx_r - 5'd1);
        end else begin
            take_s     = 1'b0;
            set_mask_s = 18'd0;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == 5'd18) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, handshake flags and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= 5'd2;
            rem_r       <= 13'd0;
            code_r      <= 18'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            // Flags are registered copies of the decoded next state
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == RUN);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        code_r <= {17'd0, v_in[0]};
                        rem_r  <= {v_in[12:1], 1'b0};
                        idx_r  <= 5'd2;
                    end else begin
                        code_r <= code_r;
                        rem_r  <= rem_r;
                        idx_r  <= idx_r;
                    end
                end
                RUN: begin
                    if (take_s) begin
                        code_r <= code_r | set_mask_s;
                        rem_r  <= rem_r - weight_s;
                    end else begin
                        code_r <= code_r;
                        rem_r  <= rem_r;
                    end
                    idx_r <= idx_r + 5'd1;
                end
                DONE: begin
                    // Held untouched under backpressure
                    code_r <= code_r;
                    rem_r  <= rem_r;
                    idx_r  <= idx_r;
                end
                default: begin
                    code_r <= 18'd0;
                    rem_r  <= 13'd0;
                    idx_r  <= 5'd2;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign d_out     = code_r;

endmodule

// File: tb/tb_nbcac_13di_encoder_seq.sv
// ----------------------------------------------------------------------------
// tb_nbcac_13di_encoder_seq
// Directed table of words with hand-computed codewords, a strided sweep with
// an independent weighted-sum decoder and handshake-spacing check, plus
// hand-written backpressure and mid-run reset sequences.
// ----------------------------------------------------------------------------
module tb_nbcac_13di_encoder_seq;

    typedef struct {
        logic [12:0] v;
        logic [17:0] d;
    } vec_t;

    localparam int WT [18] = '{1, 3194, 1974, 1220, 754, 466, 288, 178, 110,
                               68, 42, 26, 16, 10, 6, 4, 2, 2};

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] v_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] d_out;
    logic        busy;

    int tests;
    int fails;
    int cyc_count;

    nbcac_13di_encoder_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v_in      (v_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter for spacing measurements
    always @(posedge clk) cyc_count <= cyc_count + 1;

    function automatic int decode(input logic [17:0] d);
        int s;
        s = 0;
        for (int k = 0; k < 18; k++) begin
            if (d[k]) s += WT[k];
        end
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 60) begin
            tick();
            t++;
        end
        check("in_ready_timeout", int'(in_ready), 1);
    endtask

    // Accept one word, check latency and codeword, then hand it off
    task automatic run_word(input logic [12:0] v, input logic [17:0] exp_d);
        int t;
        wait_ready();
        v_in     = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        t = 0;
        while (!out_valid && t < 40) begin
            tick();
            t++;
        end
        check("latency", t, 17);
        check("codeword", int'(d_out), int'(exp_d));
        check("decode", decode(d_out), int'(v));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", int'(out_valid), 0);
    endtask

    vec_t vecs [10];
    int   prev_acc;
    int   acc;
    int   t;
    logic bp_bad;
    logic [17:0] held;

    initial begin
        tests     = 0;
        fails     = 0;
        cyc_count = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        v_in      = 13'd0;

        vecs[0] = '{13'd0,    18'h00000};
        vecs[1] = '{13'd1,    18'h00001};
        vecs[2] = '{13'd100,  18'h04A00};
        vecs[3] = '{13'd8191, 18'h041FF};
        vecs[4] = '{13'd2,    18'h10000};
        vecs[5] = '{13'd3,    18'h10001};
        vecs[6] = '{13'd4,    18'h08000};
        vecs[7] = '{13'd3194, 18'h00002};
        vecs[8] = '{13'd8190, 18'h041FE};
        vecs[9] = '{13'd12,   18'h12000};

        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_d_out", int'(d_out), 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_word(vecs[i].v, vecs[i].d);
        end

        // Strided back-to-back sweep with out_ready held high
        prev_acc  = -1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int v = 0; v < 8192; v += 97) begin
            wait_ready();
            v_in = 13'(v);
            tick();
            acc = cyc_count;
            if (prev_acc >= 0) check("spacing", acc - prev_acc, 19);
            prev_acc = acc;
            // RUN must ignore a changing v_in
            v_in = 13'h1555;
            t = 0;
            while (!out_valid && t < 40) begin
                tick();
                t++;
            end
            check("sweep_decode", decode(d_out), v);
            if (v + 97 >= 8192) in_valid = 1'b0;
        end
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;

        // Backpressure: hold DONE for 50 clocks
        wait_ready();
        v_in     = 13'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 40) begin
            tick();
            t++;
        end
        check("bp_latency", t, 17);
        held   = d_out;
        bp_bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (d_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bp_bad = 1'b1;
        end
        check("bp_stable", int'(bp_bad), 0);
        check("bp_codeword", int'(d_out), 32'h04A00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        tick();
        check("bp_single_xfer", int'(out_valid), 0);
        check("bp_idle", int'(busy), 0);

        // Reset while idx = 9 with v_in = 8191, in_valid asserted with rst
        wait_ready();
        v_in     = 13'd8191;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check("pre_rst_busy", int'(busy), 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_d_out", int'(d_out), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        tick();
        check("midrst_no_capture", int'(busy), 0);
        run_word(13'd100, 18'h04A00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
